// File: rtl/undo_tag_decoder.sv
// Serial deframer for the undo-buffer trigger-tag line: start bit, TAGW tag bits
// (MSB first), one parity bit; adds tag-sequence checking and a saturating error count.
module undo_tag_decoder #(
  parameter int unsigned TAGW = 2,
  parameter int unsigned ODD  = 1,
  parameter int unsigned ECW  = 8
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            UnDoBuf,
  input  logic            SeqEnable,
  input  logic            Clear,
  output logic            Signal,
  output logic [TAGW-1:0] Tag,
  output logic            ParityError,
  output logic            SeqError,
  output logic [ECW-1:0]  ErrCount,
  output logic            Busy
);

  localparam int unsigned CW      = (TAGW > 1) ? $clog2(TAGW) : 1;
  localparam logic [CW-1:0] LAST  = CW'(TAGW - 1);
  localparam logic ODD_BIT        = 1'(ODD);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    SHIFT = 3'b010,
    PAR   = 3'b100
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     bit_cnt;
  logic [TAGW-1:0]   shift_reg;
  logic [TAGW-1:0]   exp_tag;
  logic              acc;

  logic              par_err_c;
  logic              seq_err_c;
  logic [TAGW-1:0]   exp_next_c;

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; data bits never restart a frame since only IDLE looks for a start
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (UnDoBuf) state_next = SHIFT;
      SHIFT:   if (bit_cnt == LAST) state_next = PAR;
      PAR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame verdict evaluated during the parity cycle; ExpTag resyncs on good tags only
  always_comb begin
    par_err_c  = acc ^ UnDoBuf;
    seq_err_c  = !par_err_c && SeqEnable && (shift_reg != exp_tag);
    exp_next_c = (par_err_c ? exp_tag : shift_reg) + TAGW'(1);
  end

  // Datapath and registered outputs
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      bit_cnt     <= '0;
      shift_reg   <= '0;
      exp_tag     <= '0;
      acc         <= ODD_BIT;
      Signal      <= 1'b0;
      Tag         <= '0;
      ParityError <= 1'b0;
      SeqError    <= 1'b0;
      ErrCount    <= '0;
      Busy        <= 1'b0;
    end else begin
      Signal      <= 1'b0;
      ParityError <= 1'b0;
      SeqError    <= 1'b0;
      Busy        <= (state_next != IDLE);
      case (state)
        IDLE: begin
          acc     <= ODD_BIT;
          bit_cnt <= '0;
        end
        SHIFT: begin
          shift_reg <= TAGW'({shift_reg, UnDoBuf});
          acc       <= acc ^ UnDoBuf;
          bit_cnt   <= bit_cnt + CW'(1);
        end
        PAR: begin
          Signal      <= 1'b1;
          Tag         <= shift_reg;
          ParityError <= par_err_c;
          SeqError    <= seq_err_c;
          exp_tag     <= exp_next_c;
          if ((par_err_c || seq_err_c) && (ErrCount != '1))
            ErrCount <= ErrCount + ECW'(1);
        end
        default: ;
      endcase
      // Clear wins over any same-cycle count or ExpTag update
      if (Clear) begin
        ErrCount <= '0;
        exp_tag  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_undo_tag_decoder.sv
// Scoreboard bench for undo_tag_decoder: stimulus pushes expected strobes, a monitor
// compares every cycle against a frame-level reference model.
module tb_undo_tag_decoder;

  localparam int unsigned TW = 3;
  localparam int unsigned OD = 1;
  localparam int unsigned EW = 3;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          UnDoBuf = 1'b0;
  logic          SeqEnable = 1'b0;
  logic          Clear = 1'b0;
  logic          Signal;
  logic [TW-1:0] Tag;
  logic          ParityError;
  logic          SeqError;
  logic [EW-1:0] ErrCount;
  logic          Busy;

  undo_tag_decoder #(.TAGW(TW), .ODD(OD), .ECW(EW)) dut (
    .Clock(Clock), .Reset(Reset), .UnDoBuf(UnDoBuf), .SeqEnable(SeqEnable),
    .Clear(Clear), .Signal(Signal), .Tag(Tag), .ParityError(ParityError),
    .SeqError(SeqError), .ErrCount(ErrCount), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [TW-1:0] tag;
    logic          perr;
    logic          serr;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc_n   = 0;
  bit   mon_en  = 0;

  // Reference model state (frame level)
  int   m_exp  = 0;
  int   m_cnt  = 0;
  int   m_tag  = 0;
  bit   exp_busy = 0;
  localparam int CMAX = (1 << EW) - 1;
  localparam int TMOD = 1 << TW;

  always @(posedge Clock) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc_n);
  endtask

  task automatic drive(input logic b, input logic se, input logic clr);
    UnDoBuf   = b;
    SeqEnable = se;
    Clear     = clr;
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(input logic clr);
    drive(1'b0, 1'($urandom), clr);
    if (clr) begin
      m_cnt = 0;
      m_exp = 0;
    end
  endtask

  task automatic send_frame(input logic [TW-1:0] t, input logic bad, input logic se,
                            input logic clr);
    exp_t e;
    logic p;
    bit   serr;
    drive(1'b1, 1'($urandom), 1'b0);
    exp_busy = 1;
    for (int i = TW - 1; i >= 0; i--) drive(t[i], 1'($urandom), 1'b0);
    p = 1'(OD) ^ (^t) ^ bad;
    drive(p, se, clr);
    serr  = !bad && se && (int'(t) != m_exp);
    m_exp = ((bad ? m_exp : int'(t)) + 1) % TMOD;
    if ((bad || serr) && m_cnt < CMAX) m_cnt++;
    if (clr) begin
      m_cnt = 0;
      m_exp = 0;
    end
    m_tag    = int'(t);
    exp_busy = 0;
    e.tag  = t;
    e.perr = bad;
    e.serr = serr;
    e.cyc  = cyc_n;
    q.push_back(e);
  endtask

  // Monitor: per-cycle state checks plus strobe scoreboard
  always @(negedge Clock) begin
    if (mon_en) begin
      chk("busy", Busy, exp_busy);
      chk("tag_hold", Tag, m_tag);
      chk("errcount", ErrCount, m_cnt);
      if (Signal) begin
        if (q.size() == 0) chk("unexpected_signal", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("latency", cyc_n, e.cyc);
          chk("parity_error", ParityError, e.perr);
          chk("seq_error", SeqError, e.serr);
          chk("strobe_tag", Tag, e.tag);
        end
      end else begin
        chk("parity_error_idle", ParityError, 0);
        chk("seq_error_idle", SeqError, 0);
        if (q.size() > 0 && cyc_n >= q[0].cyc) begin
          void'(q.pop_front());
          chk("missing_signal", 0, 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge Clock);
    #1;
    mon_en = 1;
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    idle(1'b0);

    // Basic decode, then the same tag with bad parity
    send_frame(3'b101, 1'b0, 1'b0, 1'b0);
    send_frame(3'b101, 1'b1, 1'b0, 1'b0);
    idle(1'b1);

    // Sequence check: 0,1 in order, 3 out of order (back-to-back pitch)
    send_frame(3'd0, 1'b0, 1'b1, 1'b0);
    send_frame(3'd1, 1'b0, 1'b1, 1'b0);
    send_frame(3'd3, 1'b0, 1'b1, 1'b0);
    send_frame(3'd4, 1'b0, 1'b1, 1'b0);
    send_frame(3'd7, 1'b0, 1'b1, 1'b0);
    send_frame(3'd0, 1'b0, 1'b1, 1'b0);

    // Saturation, then Clear coincident with an error frame
    for (int i = 0; i < 9; i++) send_frame(3'($urandom), 1'b1, 1'b0, 1'b0);
    send_frame(3'd2, 1'b1, 1'b0, 1'b1);
    idle(1'b0);

    // Reset during the first tag bit discards the frame
    send_frame(3'd6, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    exp_busy = 1;
    drive(1'b1, 1'b0, 1'b0);
    Reset    = 1'b0;
    m_cnt    = 0;
    m_exp    = 0;
    m_tag    = 0;
    exp_busy = 0;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    Reset = 1'b1;
    idle(1'b0);
    send_frame(3'd0, 1'b0, 1'b1, 1'b0);
    send_frame(3'd6, 1'b0, 1'b1, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle($urandom_range(0, 7) == 0);
      send_frame(3'($urandom), $urandom_range(0, 3) == 0, 1'($urandom),
                 $urandom_range(0, 9) == 0);
    end

    repeat (4) idle(1'b0);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/undo_tag_decoder.md
# undo_tag_decoder

Parametrised serial decoder for the undo-buffer trigger-tag line. It deframes fixed-length frames of start bit, TAGW tag bits and one parity bit arriving at one bit per clock. For each frame it emits a one-clock strobe with the decoded tag and a parity verdict. Beyond the fixed 2-bit decoder it replaces, it checks tag sequence continuity and keeps a saturating error count, so the event-builder side can detect lost or corrupted undo signals.

## Interface
Parameters:
- TAGW, 2: tag width in bits; legal range 1 to 8.
- ODD, 1: parity sense. 1 means XOR of tag bits and parity bit must be 1; 0 means it must be 0.
- ECW, 8: error-counter width in bits; minimum 1.

Ports:
- Clock  in  1  100 MHz system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low; low forces all state to reset values immediately.
- UnDoBuf  in  1  serial input, already synchronous to Clock.
- SeqEnable  in  1  1 enables the tag-sequence check; sampled on the parity cycle.
- Clear  in  1  synchronous; 1 zeroes ErrCount and ExpTag.
- Signal  out  1  one-clock frame-complete strobe.
- Tag  out  TAGW  decoded tag, MSB received first; holds until the next frame completes.
- ParityError  out  1  valid with Signal; 1 means parity failed.
- SeqError  out  1  valid with Signal; 1 means tag differed from expected.
- ErrCount  out  ECW  saturating count of erroneous frames.
- Busy  out  1  1 while a frame is being received (states SHIFT or PAR).

## Operation
- State machine states: IDLE, SHIFT, PAR. Encoding is one-hot.
  - IDLE: UnDoBuf=1 goes to SHIFT; otherwise stay in IDLE.
  - SHIFT: shift UnDoBuf into the tag shift register, left-shift, MSB first. Bit counter runs 0..TAGW-1. Go to PAR after the bit taken with count TAGW-1.
  - PAR: sample the parity bit, update outputs, then go to IDLE unconditionally.
- Parity: accumulator is initialised to ODD in IDLE and XORs each tag bit. In PAR, ParityError = acc ^ UnDoBuf.
- Sequence check: ExpTag register, TAGW bits, reset value 0. On each PAR cycle:
  - If parity is good and SeqEnable=1: SeqError = (received tag != ExpTag).
  - Otherwise: SeqError = 0.
  - In every case ExpTag <= (parity good ? received tag : ExpTag) + 1, mod 2^TAGW. This resynchronises on good tags.
- ErrCount increments by 1 on a PAR cycle where ParityError or SeqError is 1, at most 1 per frame. It holds at all-ones when saturated and never wraps.
- Clear=1 sets ErrCount=0 and ExpTag=0 on that edge. This overrides any increment or ExpTag update in the same cycle. Clear does not affect Signal, ParityError, SeqError or Tag for that frame.
- Signal, ParityError and SeqError are registered in PAR and return to 0 on the next edge. Tag updates on the same edge Signal rises.
- Reset values: state IDLE, Signal 0, Tag 0, ParityError 0, SeqError 0, ErrCount 0, Busy 0, ExpTag 0, counter 0.
- An asserted Reset mid-frame discards the partial frame, and no Signal is issued.

## Timing
- Start bit is sampled at edge k. Tag bits are sampled at edges k+1..k+TAGW. Parity is sampled at edge k+TAGW+1.
- Signal, ParityError, SeqError and the new Tag are high or valid for the cycle between edges k+TAGW+1 and k+TAGW+2. Latency from start bit to strobe is TAGW+1 clocks.
- Busy=1 from edge k through edge k+TAGW+1 and drops at edge k+TAGW+1. Busy is 0 while Signal is 1.
- Back-to-back frames: the next start bit may be sampled at edge k+TAGW+2, the cycle in which Signal is high. Minimum frame pitch is TAGW+2 clocks.
- UnDoBuf is ignored as a start condition while in SHIFT or PAR. Data bits equal to 1 never restart a frame.
- ErrCount reflects a frame's error one edge after PAR, i.e. concurrently with Signal.

## Test plan
- TAGW=2, ODD=1: send start 1, tag 10, parity 0. Signal pulses for 1 clock at k+3 with Tag=2'b10 and ParityError=0.
- Same frame with parity 1. ParityError=1 with Signal, ErrCount becomes 1, and ExpTag increments from its prior value.
- SeqEnable=1: send good-parity tags 0,1,3. SeqError=1 only on tag 3, ErrCount=1, and the next expected tag is 0 (3+1 wraps mod 4).
- Send back-to-back frames at a pitch of TAGW+2 clocks. Two Signal pulses occur exactly TAGW+2 clocks apart, both decoded correctly, and Busy stays low only during the Signal cycles.
- ECW=2: send 5 parity-error frames. ErrCount goes 1,2,3,3,3. Then assert Clear coincident with a 6th error frame: ErrCount reads 0 after that edge and ParityError still pulses.
- Pull Reset low at edge k+1 of a TAGW=4 frame. No Signal appears, all outputs read 0, and a fresh frame after release decodes correctly.
